// File: rtl/uart_tx_reader.sv
// Reads NUM_BYTES bytes from a synchronous BRAM starting at address 0 and sends them as 8N1 UART frames.
// Optional `UART_TX_READER_CHECKSUM_EN appends one frame carrying the XOR of all data bytes.
module uart_tx_reader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 16384
) (
    input  logic        clock_100,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [7:0]  mem_Din,
    output logic [17:0] mem_addrs,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_end
);

    localparam int              TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [17:0]     ADDR_LAST = 18'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_START, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [17:0]     addr_q;
    logic            tx_q;
    logic            busy_q;
    logic            end_q;
`ifdef UART_TX_READER_CHECKSUM_EN
    logic [7:0]      csum_q;
    logic            csum_phase_q;
`endif

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
`ifdef UART_TX_READER_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    addr_q <= '0;
`ifdef UART_TX_READER_CHECKSUM_EN
                    csum_q       <= '0;
                    csum_phase_q <= 1'b0;
`endif
                    if (tx_start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                // Address was presented last cycle; BRAM output is valid at the next edge.
                S_FETCH: state_q <= S_LATCH;
                S_LATCH: begin
`ifdef UART_TX_READER_CHECKSUM_EN
                    if (csum_phase_q) begin
                        shift_q <= csum_q;
                    end else begin
                        shift_q <= mem_Din;
                        csum_q  <= csum_q ^ mem_Din;
                    end
`else
                    shift_q <= mem_Din;
`endif
                    tx_q    <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        if (addr_q < ADDR_LAST) begin
                            addr_q  <= addr_q + 18'd1;
                            state_q <= S_FETCH;
`ifdef UART_TX_READER_CHECKSUM_EN
                        end else if (!csum_phase_q) begin
                            csum_phase_q <= 1'b1;
                            state_q      <= S_FETCH;
`endif
                        end else begin
                            busy_q  <= 1'b0;
                            end_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                // Terminal until reset; tx_start is deliberately ignored.
                S_DONE: tx_q <= 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addrs = addr_q;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign tx_end    = end_q;

endmodule

// File: tb/tb_uart_tx_reader.sv
// Bench for uart_tx_reader: table-driven and random transfers checked against a waveform model.
module tb_uart_tx_reader;

    localparam int C  = 4;
    localparam int NB = 3;
    localparam int P  = 10 * C + 2;
`ifdef UART_TX_READER_CHECKSUM_EN
    localparam int NF = NB + 1;
`else
    localparam int NF = NB;
`endif
    localparam int LEN = NF * P + 60;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        bit         pulse;
        logic [7:0] csum;
        int         lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [7:0]  mem_Din;
    logic [17:0] mem_addrs;
    logic        tx;
    logic        tx_busy;
    logic        tx_end;

    logic [7:0]  mem [0:NB-1];
    logic [7:0]  frm [0:NF-1];
    logic        s_tx   [LEN];
    logic        s_busy [LEN];
    logic        s_end  [LEN];
    logic [17:0] s_addr [LEN];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    vec_t vecs [4];

    uart_tx_reader #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
        .clock_100 (clk),
        .reset     (rst),
        .tx_start  (tx_start),
        .mem_Din   (mem_Din),
        .mem_addrs (mem_addrs),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_end    (tx_end)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [17:0] a);
        if (int'(a) < NB) return mem[int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk) mem_Din <= mem_rd(mem_addrs);

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Ideal line level k cycles after the edge that accepted tx_start.
    function automatic int exp_tx(input int k);
        int rel, j, o, b;
        if (k < 2) return 1;
        rel = k - 2;
        j = rel / P;
        o = rel % P;
        if (j >= NF || o >= 10 * C) return 1;
        b = o / C;
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(frm[j][b-1]);
    endfunction

    function automatic int exp_addr(input int k);
        int a = k / P;
        return (a > NB - 1) ? NB - 1 : a;
    endfunction

    task automatic set_frames(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] cs);
        mem[0] = b0; mem[1] = b1; mem[2] = b2;
        frm[0] = b0; frm[1] = b1; frm[2] = b2;
`ifdef UART_TX_READER_CHECKSUM_EN
        frm[NB] = cs;
`else
        if (cs == 8'h00) frm[0] = b0;
`endif
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, " rst tx"}, int'(tx), 1);
        check({tag, " rst busy"}, int'(tx_busy), 0);
        check({tag, " rst end"}, int'(tx_end), 0);
        check({tag, " rst addr"}, int'(mem_addrs), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Must be entered on a falling edge; the next rising edge is E.
    task automatic run(input bit pulse);
        tx_start = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            @(posedge clk);
            #1;
            s_tx[k] = tx; s_busy[k] = tx_busy; s_end[k] = tx_end; s_addr[k] = mem_addrs;
            if (pulse && k == 0) tx_start = 1'b0;
            if (!pulse && k == NF * P + 1) tx_start = 1'b0;
            if (!pulse && k == NF * P + 21) tx_start = 1'b1;
        end
        tx_start = 1'b0;
    endtask

    task automatic analyze(input string tag, input int exp_lat);
        int mism, lat, bad_frame, bad_gap, sticky_bad, k, s, prev_end;
        logic [7:0] byt;
        logic [7:0] got [$];
        int addrs [$];
        mism = 0; lat = -1; bad_frame = 0; bad_gap = 0; sticky_bad = 0; prev_end = -1;
        for (int i = 0; i < LEN; i++) begin
            if (int'(s_tx[i]) != exp_tx(i) || s_busy[i] != (i < NF * P) ||
                s_end[i] != (i >= NF * P) || int'(s_addr[i]) != exp_addr(i)) mism++;
            if (lat < 0 && s_end[i]) lat = i;
            if (i >= NF * P && !(s_tx[i] && s_end[i] && !s_busy[i])) sticky_bad++;
            if (addrs.size() == 0 || addrs[addrs.size()-1] != int'(s_addr[i])) addrs.push_back(int'(s_addr[i]));
        end
        check({tag, " waveform mismatches"}, mism, 0);
        check({tag, " tx_end latency"}, lat, exp_lat);
        check({tag, " sticky done"}, sticky_bad, 0);
        k = 1;
        while (k < LEN - 10 * C) begin
            if (!s_tx[k] && s_tx[k-1]) begin
                s = k;
                for (int b = 0; b < 8; b++) byt[b] = s_tx[s + C * (b + 1) + C / 2];
                if (s_tx[s + C / 2] != 1'b0 || s_tx[s + 9 * C + C / 2] != 1'b1) bad_frame++;
                for (int t = s; t < s + C; t++) if (s_tx[t] != 1'b0) bad_frame++;
                if (prev_end >= 0 && s - prev_end != 2) bad_gap++;
                prev_end = s + 10 * C;
                got.push_back(byt);
                k = s + 10 * C;
            end else begin
                k++;
            end
        end
        check({tag, " frame count"}, got.size(), NF);
        check({tag, " framing errors"}, bad_frame, 0);
        check({tag, " gap errors"}, bad_gap, 0);
        for (int j = 0; j < NF && j < got.size(); j++)
            check($sformatf("%s byte%0d", tag, j), int'(got[j]), int'(frm[j]));
        check({tag, " addr seq length"}, addrs.size(), NB);
        for (int j = 0; j < NB && j < addrs.size(); j++)
            check($sformatf("%s addr%0d", tag, j), addrs[j], j);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        bit rp;
        rst = 1'b1;
        tx_start = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00;

        vecs[0].b0 = 8'h55; vecs[0].b1 = 8'hA3; vecs[0].b2 = 8'h0F; vecs[0].pulse = 1'b0; vecs[0].csum = 8'hF9;
        vecs[1].b0 = 8'h55; vecs[1].b1 = 8'hA3; vecs[1].b2 = 8'h0F; vecs[1].pulse = 1'b1; vecs[1].csum = 8'hF9;
        vecs[2].b0 = 8'h00; vecs[2].b1 = 8'hFF; vecs[2].b2 = 8'h80; vecs[2].pulse = 1'b0; vecs[2].csum = 8'h7F;
        vecs[3].b0 = 8'hFF; vecs[3].b1 = 8'h01; vecs[3].b2 = 8'h7E; vecs[3].pulse = 1'b1; vecs[3].csum = 8'h80;
`ifdef UART_TX_READER_CHECKSUM_EN
        for (int i = 0; i < 4; i++) vecs[i].lat = 168;
`else
        for (int i = 0; i < 4; i++) vecs[i].lat = 126;
`endif

        for (int i = 0; i < 4; i++) begin
            set_frames(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].csum);
            do_reset($sformatf("vec%0d", i));
            run(vecs[i].pulse);
            analyze($sformatf("vec%0d", i), vecs[i].lat);
        end

        for (int i = 0; i < 4; i++) begin
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
            rp = 1'($urandom_range(0, 1));
            set_frames(r0, r1, r2, r0 ^ r1 ^ r2);
            do_reset($sformatf("rnd%0d", i));
            run(rp);
            analyze($sformatf("rnd%0d", i), NF * P);
        end

        // Reset in the middle of bit 3 of byte 1, then restart with tx_start still high.
        set_frames(8'h55, 8'hA3, 8'h0F, 8'hF9);
        do_reset("mid");
        tx_start = 1'b1;
        for (int k = 0; k <= 61; k++) begin
            @(posedge clk);
            #1;
        end
        check("mid pre-reset tx", int'(tx), exp_tx(61));
        check("mid pre-reset addr", int'(mem_addrs), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset tx", int'(tx), 1);
        check("mid reset busy", int'(tx_busy), 0);
        check("mid reset addr", int'(mem_addrs), 0);
        check("mid reset end", int'(tx_end), 0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0);
        analyze("mid restart", NF * P);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_reader.md
# uart_tx_reader

Readback transmitter for the image memory. After the processor finishes, the communication controller raises `tx_start`. This block then reads the processed image out of the shared memory sequentially, from address 0, and serializes each byte onto the UART line as 8N1. When the last byte has left the line it raises a sticky `tx_end`. It drives the memory address path that the communication controller muxes into memory while in its TX state, and it is the transmit-side counterpart of the UART receive path that loads the memory.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: `clock_100` cycles per UART bit (115200 baud at 100 MHz). Must be ≥ 2.
- `NUM_BYTES`, default 16384: number of memory bytes sent, at addresses 0 … NUM_BYTES-1. Range 1 … 2^18.

Ports:
- `clock_100`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `tx_start`, input, 1: level request from the communication controller.
- `mem_Din`, input, 8: memory read data, valid one cycle after `mem_addrs` changes (synchronous BRAM).
- `mem_addrs`, output, 18: registered read address.
- `tx`, output, 1: UART serial line, idle high.
- `tx_busy`, output, 1: high from transfer start until `tx_end`.
- `tx_end`, output, 1: sticky completion flag.

## Operation

States: IDLE, FETCH, LATCH, START, DATA, STOP, DONE.
- **IDLE**: `tx` = 1 and `mem_addrs` = 0. If `tx_start` = 1, go to FETCH and set `tx_busy`. `tx_start` is sampled as a level, not an edge.
- **FETCH**: `mem_addrs` holds the current byte address. Wait one cycle for memory latency, then go to LATCH.
- **LATCH**: load `mem_Din` into the 8-bit shift register. Drive `tx` = 0 (start bit) and clear the bit-timer. Go to START.
- **START**: hold `tx` = 0 for CLKS_PER_BIT cycles counted from LATCH. Then drive shift[0] and go to DATA.
- **DATA**: send the byte LSB first; each bit lasts CLKS_PER_BIT cycles. After bit 7, drive `tx` = 1 and go to STOP.
- **STOP**: hold `tx` = 1 for CLKS_PER_BIT cycles.
  - If the address is below NUM_BYTES-1: increment `mem_addrs` and go to FETCH.
  - Otherwise: go to DONE.
- **DONE**: `tx` = 1, `tx_busy` = 0, `tx_end` = 1. DONE is terminal until `reset`.
  - `tx_start` is ignored here. The controller drops `tx_start` once `tx_end` is seen, and `tx_end` must not fall in response.

Rules:
- `tx_start` deasserting mid-transfer has no effect; the transfer always runs to completion.
- The bit-timer is a counter of width clog2(CLKS_PER_BIT), counting 0 … CLKS_PER_BIT-1.
- The address counter is 18 bits wide. It never wraps, because DONE is reached at NUM_BYTES-1.
- `mem_addrs` is stable for the whole frame of each byte, and changes only on the STOP→FETCH edge.

## Timing

- Reset values: `tx` = 1, `tx_busy` = 0, `tx_end` = 0, `mem_addrs` = 0, state = IDLE, shift register = 0.
- Let edge E be the edge at which IDLE samples `tx_start` = 1:
  - `tx_busy` rises at E.
  - `tx` falls at edge E+2.
- Each frame is 10·CLKS_PER_BIT cycles.
- Gap between frames: 2 cycles of idle-high (FETCH, LATCH). Byte period is 10·CLKS_PER_BIT + 2.
- `tx_end` rises on the edge that ends the final stop bit, at the same edge where `tx_busy` falls.
- Total latency from E to `tx_end` = NUM_BYTES·(10·CLKS_PER_BIT + 2) cycles.
- Reset asserted mid-frame: outputs return to their reset values immediately, without waiting for a clock edge. A partial frame on `tx` is acceptable.

## Configuration

Macro: `UART_TX_READER_CHECKSUM_EN`.
- **Defined**: a running XOR of all transmitted data bytes is kept, cleared in IDLE. After the stop bit of byte NUM_BYTES-1, one extra frame carrying the XOR value is sent, with the same 2-cycle gap. `tx_end` rises after that frame's stop bit, and total latency grows by one byte period. `mem_addrs` holds NUM_BYTES-1 during the checksum frame.
- **Undefined**: no checksum logic; behaviour exactly as above.

## Test plan

All scenarios use CLKS_PER_BIT = 4 and NUM_BYTES = 3; memory holds 0x55, 0xA3, 0x0F at addresses 0, 1, 2.

- **Basic transfer**: raise `tx_start` and hold it → decoder captures 0x55, 0xA3, 0x0F. `tx_end` rises exactly 126 cycles after E; `mem_addrs` sequence is 0, 1, 2.
- **Framing**: during the same run, check every frame → each bit lasts 4 cycles, start bit = 0, stop bit = 1, and the inter-frame gap is 2 high cycles.
- **Sticky completion**: drop `tx_start` 1 cycle after `tx_end` rises, then re-raise it 20 cycles later → `tx_end` stays 1, `tx` stays 1, and no new frame is sent.
- **Early release**: pulse `tx_start` for 1 cycle only → full 3-byte transfer completes identically to the basic case.
- **Mid-frame reset**: assert `reset` during bit 3 of byte 1 → `tx` = 1, `tx_busy` = 0, `mem_addrs` = 0 immediately. After release, with `tx_start` high, the transfer restarts from address 0.
- **Checksum** (with `UART_TX_READER_CHECKSUM_EN` defined): basic stimulus → a 4th byte 0xF9 is received; `tx_end` rises 168 cycles after E.
